decode_writeback: RTL

Decode/write-back stage of the sequential Y86-64 core, directly upstream of the ALU argument mux. It holds the 15-entry program register file. From `icode`/`rA`/`rB` it selects source and destination register IDs and drives `valA`/`valB` into execute. At the end of each instruction it commits `valE`/`valM` back to the file under a one-cycle write strobe from the sequencer.

---
 rtl/decode_writeback.sv | 126 ++++++++++++
 1 files changed

// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 decode/write-back stage with the 15-entry program register file.
// Register ID 4'hF is "no register": reads return 0, writes are dropped.
module decode_writeback #(
  parameter logic [63:0] RSP_RESET = 64'h0,
  parameter logic [63:0] REG_RESET = 64'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         icode,
  input  logic [3:0]         rA,
  input  logic [3:0]         rB,
  input  logic               cnd,
  input  logic [63:0]        valP,
  input  logic signed [63:0] valE,
  input  logic signed [63:0] valM,
  input  logic               wb_en,
  output logic [3:0]         srcA,
  output logic [3:0]         srcB,
  output logic [3:0]         dstE,
  output logic [3:0]         dstM,
  output logic signed [63:0] valA,
  output logic signed [63:0] valB,
  input  logic [3:0]         dbg_idx,
  output logic [63:0]        dbg_val
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  logic [63:0] regs [0:14];
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic [63:0] rd_dbg;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      4'h2: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      4'h3: begin
        srcB = rB;
        dstE = rB;
      end
      4'h4: begin
        srcA = rA;
        srcB = rB;
      end
      4'h5: begin
        srcB = rB;
        dstM = rA;
      end
      4'h6: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      4'h8: begin
        srcB = RRSP;
        dstE = RRSP;
      end
      4'h9: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
      end
      4'hA: begin
        srcA = rA;
        srcB = RRSP;
        dstE = RRSP;
      end
      4'hB: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
        dstM = rA;
      end
      default: begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
      end
    endcase
  end

  // Index F matches no entry, so every read port falls back to zero.
  always_comb begin
    rd_a   = '0;
    rd_b   = '0;
    rd_dbg = '0;
    for (int i = 0; i < 15; i++) begin
      if (srcA == 4'(i)) rd_a = regs[i];
      if (srcB == 4'(i)) rd_b = regs[i];
      if (dbg_idx == 4'(i)) rd_dbg = regs[i];
    end
  end

  always_comb begin
    valA    = (icode == 4'h7 || icode == 4'h8) ? valP : rd_a;
    valB    = rd_b;
    dbg_val = rd_dbg;
  end

  // valM is checked first so popq %rsp leaves the popped value in R4.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == 4) ? RSP_RESET : REG_RESET;
      end
    end else if (wb_en) begin
      for (int i = 0; i < 15; i++) begin
        if (dstM == 4'(i)) begin
          regs[i] <= valM;
        end else if (dstE == 4'(i)) begin
          regs[i] <= valE;
        end
      end
    end
  end

endmodule
